// File: rtl/customized_sequence_frame_parser.sv
// Frames, validates and buffers sequence-load commands from the host byte stream;
// only fully checked frames are burst into the sequence FIFO.
module customized_sequence_frame_parser #(
   parameter logic [7:0] HEADER      = 8'hA5,
   parameter int         MAX_LEN     = 255,
   parameter int         TIMEOUT_CYC = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       sequence_wrfifo_full,
   input  logic       sequence_wrfifo_empty,
   output logic       sequence_wrfifo_req,
   output logic [7:0] sequence_wrfifo_data,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [2:0] err_code,
   output logic       busy
);

   localparam int IDX_W = 9;
   localparam int DEPTH = MAX_LEN + 3;
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [IDX_W-1:0] MAX_LEN_W = IDX_W'(MAX_LEN);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_NUMBER  = 3'd1;
   localparam logic [2:0] S_LENGTH  = 3'd2;
   localparam logic [2:0] S_CYCLE   = 3'd3;
   localparam logic [2:0] S_PAYLOAD = 3'd4;
   localparam logic [2:0] S_CHECK   = 3'd5;
   localparam logic [2:0] S_WAIT    = 3'd6;
   localparam logic [2:0] S_COMMIT  = 3'd7;

   localparam logic [2:0] E_NONE = 3'd0;
   localparam logic [2:0] E_NUM  = 3'd1;
   localparam logic [2:0] E_LEN  = 3'd2;
   localparam logic [2:0] E_CYC  = 3'd3;
   localparam logic [2:0] E_SUM  = 3'd4;
   localparam logic [2:0] E_TMO  = 3'd5;
   localparam logic [2:0] E_OVR  = 3'd6;

   function automatic logic [7:0] f_csum_add(input logic [7:0] a, input logic [7:0] b);
      return a + b;
   endfunction

   logic [2:0]       r_state;
   logic [7:0]       r_buf [0:DEPTH-1];
   logic [IDX_W-1:0] r_wr_idx;
   logic [IDX_W-1:0] r_rd_idx;
   logic [IDX_W-1:0] r_total;
   logic [7:0]       r_sum;
   logic [2:0]       r_perr;
   logic [TO_W-1:0]  r_gap;
   logic             r_frame_ok;
   logic             r_frame_err;
   logic [2:0]       r_err_code;

   logic w_timing;
   logic w_commit;
   logic w_req;
   logic w_last_wr;
   logic w_buf_we;
   logic w_timeout;

   assign w_timing  = (r_state >= S_NUMBER) && (r_state <= S_CHECK);
   assign w_commit  = (r_state == S_COMMIT);
   assign w_req     = w_commit && !sequence_wrfifo_full && (r_rd_idx < r_total);
   assign w_last_wr = w_req && (r_rd_idx == (r_total - 9'd1));
   assign w_buf_we  = rx_valid && (r_state >= S_NUMBER) && (r_state <= S_PAYLOAD);
   assign w_timeout = w_timing && !rx_valid && (r_gap == TO_LAST);

   // Req and data are gated by state so they fall together with the async reset.
   assign sequence_wrfifo_req  = w_req;
   assign sequence_wrfifo_data = w_commit ? r_buf[r_rd_idx] : 8'h00;
   assign frame_ok             = r_frame_ok;
   assign frame_err            = r_frame_err;
   assign err_code             = r_err_code;
   assign busy                 = (r_state != S_IDLE);

   always_ff @(posedge clk) begin
      if (w_buf_we) begin
         r_buf[r_wr_idx] <= rx_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_wr_idx    <= '0;
         r_rd_idx    <= '0;
         r_total     <= '0;
         r_sum       <= '0;
         r_perr      <= E_NONE;
         r_gap       <= '0;
         r_frame_ok  <= 1'b0;
         r_frame_err <= 1'b0;
         r_err_code  <= E_NONE;
      end else begin
         r_frame_ok  <= 1'b0;
         r_frame_err <= 1'b0;

         if (!w_timing || rx_valid) begin
            r_gap <= '0;
         end else if (r_gap != TO_LAST) begin
            r_gap <= r_gap + TO_W'(1);
         end

         case (r_state)
            S_IDLE: begin
               if (rx_valid && rx_data == HEADER) begin
                  r_state  <= S_NUMBER;
                  r_wr_idx <= '0;
                  r_sum    <= '0;
                  r_perr   <= E_NONE;
               end
            end
            S_NUMBER: begin
               if (rx_valid) begin
                  r_wr_idx <= r_wr_idx + 9'd1;
                  r_sum    <= f_csum_add(r_sum, rx_data);
                  if (rx_data > 8'd3) r_perr <= E_NUM;
                  r_state  <= S_LENGTH;
               end
            end
            S_LENGTH: begin
               if (rx_valid) begin
                  // A bad length leaves the frame end unknown, so abort right away.
                  if (rx_data == 8'd0 || {1'b0, rx_data} > MAX_LEN_W) begin
                     r_frame_err <= 1'b1;
                     r_err_code  <= E_LEN;
                     r_state     <= S_IDLE;
                  end else begin
                     r_wr_idx <= r_wr_idx + 9'd1;
                     r_sum    <= f_csum_add(r_sum, rx_data);
                     r_total  <= {1'b0, rx_data} + 9'd3;
                     r_state  <= S_CYCLE;
                  end
               end
            end
            S_CYCLE: begin
               if (rx_valid) begin
                  r_wr_idx <= r_wr_idx + 9'd1;
                  r_sum    <= f_csum_add(r_sum, rx_data);
                  if (rx_data == 8'd0 && r_perr == E_NONE) r_perr <= E_CYC;
                  r_state  <= S_PAYLOAD;
               end
            end
            S_PAYLOAD: begin
               if (rx_valid) begin
                  r_wr_idx <= r_wr_idx + 9'd1;
                  r_sum    <= f_csum_add(r_sum, rx_data);
                  if (r_wr_idx == (r_total - 9'd1)) r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (rx_valid) begin
                  if (r_perr != E_NONE) begin
                     r_frame_err <= 1'b1;
                     r_err_code  <= r_perr;
                     r_state     <= S_IDLE;
                  end else if (rx_data != r_sum) begin
                     r_frame_err <= 1'b1;
                     r_err_code  <= E_SUM;
                     r_state     <= S_IDLE;
                  end else begin
                     r_rd_idx <= '0;
                     r_state  <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (rx_valid) begin
                  r_frame_err <= 1'b1;
                  r_err_code  <= E_OVR;
               end
               if (sequence_wrfifo_empty) r_state <= S_COMMIT;
            end
            S_COMMIT: begin
               if (rx_valid) begin
                  r_frame_err <= 1'b1;
                  r_err_code  <= E_OVR;
               end
               if (w_req) r_rd_idx <= r_rd_idx + 9'd1;
               if (w_last_wr) begin
                  r_frame_ok <= 1'b1;
                  if (!rx_valid) r_err_code <= E_NONE;
                  r_state    <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase

         // A byte arriving in the expiry cycle wins; w_timeout already excludes it.
         if (w_timeout) begin
            r_frame_err <= 1'b1;
            r_err_code  <= E_TMO;
            r_state     <= S_IDLE;
         end
      end
   end

endmodule

// File: tb/tb_customized_sequence_frame_parser.sv
// Scoreboard bench: stimulus queues expected FIFO writes and frame events,
// a negedge monitor pops and compares whatever the parser presents.
module tb_customized_sequence_frame_parser;

   localparam int TMO = 64;

   localparam logic [1:0] K_WR  = 2'd0;
   localparam logic [1:0] K_OK  = 2'd1;
   localparam logic [1:0] K_ERR = 2'd2;

   typedef struct packed {
      logic [1:0] kind;
      logic [7:0] val;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       wr_full = 1'b0;
   logic       wr_empty = 1'b1;
   logic       wr_req;
   logic [7:0] wr_data;
   logic       frame_ok;
   logic       frame_err;
   logic [2:0] err_code;
   logic       busy;

   exp_t       sb [$];
   logic [7:0] fr [$];
   int         total = 0;
   int         bad = 0;

   customized_sequence_frame_parser #(
      .HEADER(8'hA5), .MAX_LEN(255), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
      .sequence_wrfifo_full(wr_full), .sequence_wrfifo_empty(wr_empty),
      .sequence_wrfifo_req(wr_req), .sequence_wrfifo_data(wr_data),
      .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code), .busy(busy)
   );

   always #5 clk = ~clk;

   function automatic void chk(input string nm, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", nm, act, req);
      end
   endfunction

   task automatic pop_check(input logic [1:0] k, input logic [7:0] v);
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL unexpected_event: kind=%0d val=%02h want=none", k, v);
      end else begin
         e = sb.pop_front();
         chk("event_kind", int'(k), int'(e.kind));
         chk("event_val", int'(v), int'(e.val));
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_req)    pop_check(K_WR, wr_data);
         if (frame_ok)  pop_check(K_OK, {5'd0, err_code});
         if (frame_err) pop_check(K_ERR, {5'd0, err_code});
      end
   end

   task automatic send(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_fr();
      foreach (fr[i]) send(fr[i]);
   endtask

   task automatic exp_good();
      for (int i = 1; i < fr.size() - 1; i++) sb.push_back('{K_WR, fr[i]});
      sb.push_back('{K_OK, 8'h00});
   endtask

   task automatic exp_err(input logic [7:0] code);
      sb.push_back('{K_ERR, code});
   endtask

   task automatic drain(input string nm);
      int n;
      n = 0;
      while (sb.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL %s_drain: left=%0d want=0", nm, sb.size());
         sb.delete();
      end
      repeat (4) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic wait_reqs(input int cnt, input string nm);
      int seen;
      int n;
      seen = 0;
      n = 0;
      while (seen < cnt && n < 200) begin
         @(negedge clk);
         if (wr_req) seen++;
         n++;
      end
      if (seen < cnt) begin
         total++;
         bad++;
         $display("FAIL %s_wait_req: got=%0d want=%0d", nm, seen, cnt);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int nreq;

      #1;
      chk("rst_req", wr_req, 0);
      chk("rst_data", wr_data, 0);
      chk("rst_ok", frame_ok, 0);
      chk("rst_err", frame_err, 0);
      chk("rst_code", err_code, 0);
      chk("rst_busy", busy, 0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Good frame with exact commit timing.
      fr = '{8'hA5, 8'h02, 8'h03, 8'h05, 8'h01, 8'h00, 8'h01, 8'h0C};
      exp_good();
      send_fr();
      @(negedge clk);
      chk("good_wait_cycle_req", wr_req, 0);
      @(negedge clk);
      chk("good_first_req", wr_req, 1);
      n = 0;
      while (wr_req && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("good_burst_len", n, 6);
      chk("good_ok_after_burst", frame_ok, 1);
      drain("good");

      // Bad checksum, then a good frame.
      fr = '{8'hA5, 8'h02, 8'h03, 8'h05, 8'h01, 8'h00, 8'h01, 8'h0D};
      exp_err(8'd4);
      send_fr();
      drain("badsum");
      fr = '{8'hA5, 8'h02, 8'h03, 8'h05, 8'h01, 8'h00, 8'h01, 8'h0C};
      exp_good();
      send_fr();
      drain("good2");

      // Number out of range with a valid checksum.
      fr = '{8'hA5, 8'h04, 8'h03, 8'h05, 8'h01, 8'h00, 8'h01, 8'h0E};
      exp_err(8'd1);
      send_fr();
      drain("num");

      // Length zero aborts immediately; next header restarts framing.
      fr = '{8'hA5, 8'h02, 8'h00};
      exp_err(8'd2);
      send_fr();
      chk("len0_err_now", frame_err, 1);
      chk("len0_code_now", err_code, 2);
      chk("len0_busy", busy, 0);
      fr = '{8'hA5, 8'h01, 8'h01, 8'h09, 8'h33, 8'h3E};
      exp_good();
      send_fr();
      drain("len0_next");

      // FIFO not empty for 20 cycles, then full for 3 cycles mid-commit.
      wr_empty = 1'b0;
      fr = '{8'hA5, 8'h01, 8'h02, 8'h07, 8'hAA, 8'hBB, 8'h6F};
      exp_good();
      send_fr();
      nreq = 0;
      repeat (20) begin
         @(negedge clk);
         if (wr_req) nreq++;
      end
      chk("nonempty_no_wr", nreq, 0);
      chk("nonempty_busy", busy, 1);
      @(posedge clk);
      #1 wr_empty = 1'b1;
      wait_reqs(2, "bp");
      @(posedge clk);
      #1 wr_full = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("full_req_low", wr_req, 0);
         chk("full_data_hold", wr_data, 8'h07);
      end
      @(posedge clk);
      #1 wr_full = 1'b0;
      drain("bp");

      // Header value as payload, plus an overrun byte while waiting for empty.
      wr_empty = 1'b0;
      fr = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'hA5, 8'hAB};
      exp_err(8'd6);
      exp_good();
      send_fr();
      send(8'h55);
      repeat (3) @(posedge clk);
      #1 wr_empty = 1'b1;
      drain("overrun");

      // Timeout after a partial frame, then garbage and a valid frame.
      fr = '{8'hA5, 8'h01};
      exp_err(8'd5);
      send_fr();
      n = 0;
      while (!frame_err && n < 4 * TMO) begin
         @(negedge clk);
         n++;
      end
      chk("tmo_cycles", n, TMO + 1);
      chk("tmo_code", err_code, 5);
      chk("tmo_busy", busy, 0);
      drain("tmo");
      send(8'h11);
      send(8'h22);
      fr = '{8'hA5, 8'h02, 8'h03, 8'h05, 8'h01, 8'h00, 8'h01, 8'h0C};
      exp_good();
      send_fr();
      drain("resync");

      // Cycle zero.
      fr = '{8'hA5, 8'h02, 8'h03, 8'h00, 8'h01, 8'h00, 8'h01, 8'h07};
      exp_err(8'd3);
      send_fr();
      drain("cyc0");

      // Reset in the middle of a commit.
      fr = '{8'hA5, 8'h02, 8'h03, 8'h05, 8'h01, 8'h00, 8'h01, 8'h0C};
      exp_good();
      send_fr();
      wait_reqs(2, "rstc");
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rstc_req", wr_req, 0);
      chk("rstc_ok", frame_ok, 0);
      chk("rstc_err", frame_err, 0);
      chk("rstc_code", err_code, 0);
      chk("rstc_busy", busy, 0);
      sb.delete();
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("rstc_idle", busy, 0);
      exp_good();
      send_fr();
      drain("after_rst");

      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/customized_sequence_frame_parser.md
Name: customized_sequence_frame_parser

Overview:
Upstream feeder for the customized sequence controller. Takes the raw command byte stream from the host receive path, frames and validates each sequence-load command (header, channel, length, cycle, payload, checksum), and buffers it. Only fully validated frames are written into the sequence FIFO, as one back-to-back burst. The controller therefore never sees a partial or corrupt frame.

Parameters:
HEADER, 8'hA5, frame start byte
MAX_LEN, 255, maximum payload length in bytes (1..255)
TIMEOUT_CYC, 50000, idle cycles between bytes before an in-progress frame is aborted

Ports:
clk  input  1  system clock
rst_n  input  1  reset; asynchronous, active-low
rx_data  input  8  received byte
rx_valid  input  1  one-cycle strobe, rx_data valid
sequence_wrfifo_full  input  1  sequence FIFO full
sequence_wrfifo_empty  input  1  sequence FIFO empty
sequence_wrfifo_req  output  1  FIFO write enable; data accepted the same cycle
sequence_wrfifo_data  output  8  FIFO write data
frame_ok  output  1  one-cycle pulse: frame fully committed to FIFO
frame_err  output  1  one-cycle pulse: frame rejected
err_code  output  3  last error: 0 none, 1 number>3, 2 length 0 or >MAX_LEN, 3 cycle 0, 4 checksum, 5 timeout, 6 overrun
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values: all outputs 0; err_code 0; state IDLE; buffer contents don't-care.
- Frame format: HEADER, number, length, cycle, length payload bytes, checksum.
- Checksum rule: checksum = 8-bit wrap-around sum of number + length + cycle + all payload bytes. HEADER is excluded.
- Buffer: 3+MAX_LEN bytes, indexed by wr_idx. Order is number, length, cycle, payload.
- State IDLE:
  - rx_valid with rx_data==HEADER -> NUMBER.
  - Any other byte is silently discarded (resync).
- State NUMBER:
  - Store the byte.
  - If byte>3, set pending error 1.
  - -> LENGTH.
- State LENGTH:
  - Store the byte.
  - If 0 or >MAX_LEN: frame_err pulse, err_code=2, -> IDLE immediately (frame end unknown).
  - Otherwise -> CYCLE.
- State CYCLE:
  - Store the byte.
  - If 0 and no earlier pending error, set pending error 3.
  - -> PAYLOAD.
- State PAYLOAD:
  - Store bytes while accumulating the checksum.
  - After the length-th byte -> CHECK.
- State CHECK:
  - On the next rx_valid, compare it with the accumulated sum.
  - If a pending error exists, report it with priority over a checksum mismatch.
  - On error: frame_err, err_code set, -> IDLE.
  - On match: -> WAIT_EMPTY.
- State WAIT_EMPTY: hold until sequence_wrfifo_empty==1, then -> COMMIT.
  - This guarantees one frame in the FIFO at a time, because the controller drains the FIFO after each frame.
- State COMMIT:
  - Write 3+length bytes in buffer order, one per cycle.
  - sequence_wrfifo_req = !sequence_wrfifo_full && rd_idx<total.
  - While full, stall and hold data.
  - The cycle after the last write: frame_ok pulse, err_code=0, -> IDLE.
  - Total write latency after the checksum byte = 1 + empty-wait + (3+length) + full-stall cycles.
- Timeout:
  - In NUMBER..CHECK, a gap counter resets on each rx_valid.
  - When the counter reaches TIMEOUT_CYC-1: frame_err, err_code=5, -> IDLE.
  - The counter does not run in IDLE, WAIT_EMPTY or COMMIT.
- Overrun:
  - rx_valid during WAIT_EMPTY or COMMIT: the byte is dropped, the frame_err pulse is issued, and err_code=6.
  - The current commit still completes; frame_ok still pulses at the end.
  - If both pulses fall in the same cycle, both assert and err_code=6.
- Simultaneous events:
  - rx_valid in the same cycle as a timeout expiry: the byte wins and the counter clears.
  - A HEADER value inside a frame is treated as data.
- Reset mid-operation:
  - Abort immediately.
  - sequence_wrfifo_req drops asynchronously with rst_n.
  - A partially written frame is left in the FIFO; the system must reset the FIFO together with this block.
- Widths: the 8-bit checksum wraps. rd_idx/wr_idx are 9 bits, sized to 3+MAX_LEN.

Test Plan:
- Good frame: A5,02,03,05,01,00,01,0C with FIFO empty -> 6 consecutive wr_req cycles carrying 02,03,05,01,00,01, then frame_ok, err_code=0.
- Bad checksum: same frame with last byte 0D -> no wr_req, frame_err, err_code=4; a following good frame commits normally.
- Field errors:
  - number=04 with a valid checksum -> err_code=1, no write.
  - length=00 -> err_code=2 right after the length byte, and the next A5 restarts framing.
  - cycle=00 -> err_code=3.
- FIFO back-pressure: FIFO starts non-empty for 20 cycles -> no writes until empty. Then full is asserted for 3 cycles mid-commit -> req low in those cycles, data held, no byte lost or duplicated.
- Timeout and resync: A5,01 then no bytes for TIMEOUT_CYC cycles -> frame_err, err_code=5, busy=0. Garbage bytes 11,22 then a valid frame -> accepted.
- Reset during COMMIT: assert rst_n low at byte 2 of 6 -> req=0 immediately, all outputs 0, state IDLE after release.
